// File: rtl/microcode_sequencer.sv
// microcode_sequencer
//   Drives the microcode ROM address {opcode, step} and walks through the
//   microsteps of each instruction. The ROM has a one-cycle registered read,
//   so each microstep is an ISSUE cycle (address presented and sampled)
//   followed by an EXEC cycle (control word returned and forwarded).
//
// Ports
//   clk         system clock, all state on rising edge
//   reset       asynchronous, active-high reset
//   opcode      live opcode from the instruction register
//   rom_data    control word from the ROM, valid the cycle after rom_addr is sampled
//   step_en     run/single-step permit, sampled in ISSUE only
//   resume      leave HALTED (level, sampled in HALTED only)
//   rom_addr    {opcode, step} to the ROM address port
//   ctrl_out    gated control word to the datapath (zero outside EXEC)
//   ctrl_strobe high during EXEC cycles
//   step        current microstep
//   halted      high in HALTED
//   instr_done  one-cycle pulse on the EXEC cycle that ends an instruction
//
// state   | meaning
// --------+-------------------------------------------------------------
// ISSUE   | rom_addr presented; advance to EXEC when step_en is high
// EXEC    | ROM word valid; forward it, then halt / end / next step
// HALTED  | halt bit seen; wait for resume, then restart at step 0

module microcode_sequencer #(
  parameter int STEP_W      = 4,
  parameter int MAX_STEP    = 7,
  parameter int FETCH_STEPS = 2,
  parameter int HLT_BIT     = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          opcode,
  input  logic [15:0]         rom_data,
  input  logic                step_en,
  input  logic                resume,
  output logic [STEP_W+3:0]   rom_addr,
  output logic [15:0]         ctrl_out,
  output logic                ctrl_strobe,
  output logic [STEP_W-1:0]   step,
  output logic                halted,
  output logic                instr_done
);

  typedef enum logic [1:0] {
    S_ISSUE  = 2'd0,
    S_EXEC   = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  localparam logic [STEP_W-1:0] LAST_STEP  = STEP_W'(MAX_STEP);
  localparam logic [STEP_W-1:0] FETCH_LAST = STEP_W'(FETCH_STEPS);
  localparam logic [STEP_W-1:0] STEP_ONE   = STEP_W'(1);

  state_t            state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d;

  // An all-zero word only terminates once the fetch steps are behind us;
  // during fetch a zero word is simply an idle microstep.
  logic end_word;
  logic last_step;

  assign end_word  = (rom_data == 16'h0000) && (step_q >= FETCH_LAST);
  assign last_step = (step_q == LAST_STEP);

  // opcode is live; the ROM latches whatever is on the bus at the
  // ISSUE->EXEC edge, so a mid-fetch IR load shows up on the next step.
  assign rom_addr = {opcode, step_q};
  assign step     = step_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_ISSUE;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    ctrl_out    = 16'h0000;
    ctrl_strobe = 1'b0;
    halted      = 1'b0;
    instr_done  = 1'b0;

    case (state_q)
      S_ISSUE: begin
        if (step_en) begin
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        ctrl_out    = rom_data;
        ctrl_strobe = 1'b1;
        if (rom_data[HLT_BIT]) begin
          // step is kept so the halt address stays visible on rom_addr
          state_d = S_HALTED;
        end else if (end_word || last_step) begin
          instr_done = 1'b1;
          step_d     = '0;
          state_d    = S_ISSUE;
        end else begin
          step_d  = step_q + STEP_ONE;
          state_d = S_ISSUE;
        end
      end

      S_HALTED: begin
        halted = 1'b1;
        if (resume) begin
          step_d  = '0;
          state_d = S_ISSUE;
        end
      end

      default: begin
        step_d  = '0;
        state_d = S_ISSUE;
      end
    endcase
  end

endmodule

// File: tb/tb_microcode_sequencer.sv
// tb_microcode_sequencer
//   Directed bench for microcode_sequencer. A registered ROM model feeds the
//   DUT; each instruction run pushes its expected strobe records (word, step,
//   done flag, address) into a queue, and an independent monitor pops one
//   record per ctrl_strobe cycle and compares.

module tb_microcode_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  opcode;
  logic [15:0] rom_data;
  logic        step_en;
  logic        resume;
  logic [7:0]  rom_addr;
  logic [15:0] ctrl_out;
  logic        ctrl_strobe;
  logic [3:0]  step;
  logic        halted;
  logic        instr_done;

  logic [15:0] rom [256];

  typedef struct packed {
    logic [15:0] word;
    logic [3:0]  st;
    logic        done;
    logic [7:0]  addr;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  // ROM with one-cycle registered read
  always @(posedge clk) rom_data <= rom[rom_addr];

  microcode_sequencer dut (
    .clk         (clk),
    .reset       (rst),
    .opcode      (opcode),
    .rom_data    (rom_data),
    .step_en     (step_en),
    .resume      (resume),
    .rom_addr    (rom_addr),
    .ctrl_out    (ctrl_out),
    .ctrl_strobe (ctrl_strobe),
    .step        (step),
    .halted      (halted),
    .instr_done  (instr_done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Monitor: one expected record per strobe; quiet cycles must be gated off.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (ctrl_strobe) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_strobe actual=addr 0x%0h word 0x%0h expected=no strobe",
                     rom_addr, ctrl_out);
          end else begin
            e = exp_q.pop_front();
            chk("strobe_word", ctrl_out, e.word);
            chk("strobe_step", step, e.st);
            chk("strobe_done", instr_done, e.done);
            chk("strobe_addr", rom_addr, e.addr);
          end
        end else begin
          chk("idle_ctrl_out", ctrl_out, 0);
          chk("idle_done", instr_done, 0);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=time limit reached expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic push_instr(input logic [3:0] op, input int n, input bit last_done);
    exp_t e;
    for (int s = 0; s < n; s++) begin
      e.word = rom[{op, 4'(s)}];
      e.st   = 4'(s);
      e.done = last_done && (s == n - 1);
      e.addr = {op, 4'(s)};
      exp_q.push_back(e);
    end
  endtask

  // Called at a negedge while the DUT sits in ISSUE at step 0 (cycle 1).
  task automatic run_instr(input logic [3:0] op, input int n, input bit last_done,
                           input int stall, input int exp_cyc);
    int cyc;
    bit got;
    push_instr(op, n, last_done);
    opcode  = op;
    step_en = 1'b1;
    cyc     = 1;
    got     = 1'b0;
    for (int k = 0; k < 80 && !got; k++) begin
      @(negedge clk);
      cyc++;
      if (stall > 0 && ctrl_strobe && step == 4'd0) begin
        step_en = 1'b0;
        repeat (stall) begin
          @(negedge clk);
          cyc++;
          chk("stall_strobe", ctrl_strobe, 0);
          chk("stall_addr", rom_addr, {op, 4'd1});
        end
        step_en = 1'b1;
      end else if (instr_done || halted) begin
        got = 1'b1;
      end
    end
    if (!got) chk("end_timeout", 0, 1);
    chk("instr_cycles", cyc, exp_cyc);
  endtask

  initial begin
    bit hit;
    rst     = 1'b1;
    opcode  = 4'h5;
    step_en = 1'b0;
    resume  = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    // NOP
    rom[8'h00] = 16'h4004; rom[8'h01] = 16'h1408; rom[8'h02] = 16'h0000;
    // LDA
    rom[8'h10] = 16'h4004; rom[8'h11] = 16'h1408; rom[8'h12] = 16'h4800;
    rom[8'h13] = 16'h1200; rom[8'h14] = 16'h0000;
    // eight nonzero steps; 0x28 must never be addressed
    rom[8'h20] = 16'h4004; rom[8'h21] = 16'h1408; rom[8'h22] = 16'h0111;
    rom[8'h23] = 16'h0222; rom[8'h24] = 16'h0333; rom[8'h25] = 16'h0444;
    rom[8'h26] = 16'h0555; rom[8'h27] = 16'h0666; rom[8'h28] = 16'h0777;
    // zero word inside fetch does not end the instruction
    rom[8'h30] = 16'h4004; rom[8'h31] = 16'h0000; rom[8'h32] = 16'h0000;
    // HLT
    rom[8'hF0] = 16'h4004; rom[8'hF1] = 16'h1408; rom[8'hF2] = 16'h8000;

    repeat (2) @(negedge clk);
    chk("rst_ctrl_out", ctrl_out, 0);
    chk("rst_strobe", ctrl_strobe, 0);
    chk("rst_halted", halted, 0);
    chk("rst_done", instr_done, 0);
    chk("rst_step", step, 0);
    chk("rst_addr", rom_addr, 8'h50);

    opcode = 4'h0;
    rst    = 1'b0;
    @(negedge clk);
    chk("idle_no_step_en_strobe", ctrl_strobe, 0);

    run_instr(4'h0, 3, 1'b1, 0, 6);
    @(negedge clk);
    chk("nop_step_after_done", step, 0);

    run_instr(4'h1, 5, 1'b1, 0, 10);
    @(negedge clk);
    chk("lda_step_after_done", step, 0);

    run_instr(4'h0, 3, 1'b1, 5, 10);
    @(negedge clk);

    run_instr(4'h3, 3, 1'b1, 0, 6);
    @(negedge clk);

    run_instr(4'h2, 8, 1'b1, 0, 16);
    @(negedge clk);
    chk("forced_step_zero", step, 0);
    chk("forced_addr", rom_addr, 8'h20);
    step_en = 1'b0;
    repeat (2) @(negedge clk);
    chk("forced_no_strobe", ctrl_strobe, 0);

    @(negedge clk);
    run_instr(4'hF, 3, 1'b0, 0, 7);
    step_en = 1'b0;
    chk("hlt_halted", halted, 1);
    chk("hlt_ctrl_out", ctrl_out, 0);
    chk("hlt_strobe", ctrl_strobe, 0);
    chk("hlt_addr", rom_addr, 8'hF2);
    chk("hlt_step", step, 2);
    repeat (3) @(negedge clk);
    chk("hlt_still_halted", halted, 1);
    chk("hlt_addr_held", rom_addr, 8'hF2);
    resume = 1'b1;
    @(negedge clk);
    resume = 1'b0;
    chk("resume_halted", halted, 0);
    chk("resume_step", step, 0);
    chk("resume_addr", rom_addr, 8'hF0);

    // asynchronous reset in the middle of the EXEC cycle of step 3
    push_instr(4'h1, 4, 1'b0);
    opcode  = 4'h1;
    step_en = 1'b1;
    hit     = 1'b0;
    for (int k = 0; k < 30 && !hit; k++) begin
      @(negedge clk);
      if (ctrl_strobe && step == 4'd3) hit = 1'b1;
    end
    if (!hit) chk("mid_exec_timeout", 0, 1);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_strobe", ctrl_strobe, 0);
    chk("async_rst_ctrl_out", ctrl_out, 0);
    chk("async_rst_step", step, 0);
    chk("async_rst_addr", rom_addr, 8'h10);
    chk("queue_empty_at_reset", exp_q.size(), 0);
    @(negedge clk);
    rst = 1'b0;
    run_instr(4'h1, 5, 1'b1, 0, 10);

    @(negedge clk);
    step_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
